// File: rtl/adc_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_readout_if
// Brief    : AXI-Stream sample channel between adc_readout and its consumer.
// Revision : 1.0
// ============================================================================
interface adc_readout_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/adc_readout.sv
`default_nettype none
// ============================================================================
// Module   : adc_readout
// Brief    : SPI-framed ADC sample readout to a sign-extended AXI-Stream beat.
// Revision : 1.0
// ============================================================================
module adc_readout #(
  parameter int DATA_WIDTH = 24,
  parameter int SCK_DIV    = 2,
  parameter int PACKET_LEN = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  output logic          cs_n,
  output logic          sck,
  input  logic          sdo,
  adc_readout_if.master m_axis,
  output logic          ready,
  output logic          last,
  output logic          overrun
);

  localparam int CNT_W = ($clog2(PACKET_LEN) > 16) ? $clog2(PACKET_LEN) : 16;
  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int PH_W  = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           tdata_q, tdata_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sck_q, sck_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  overrun_q, overrun_d;
  logic [31:0]           sext;
  logic                  div_done;

  generate
    if (DATA_WIDTH == 32) begin : g_sext_full
      assign sext = shreg_q;
    end else begin : g_sext_ext
      assign sext = {{(32 - DATA_WIDTH){shreg_q[DATA_WIDTH-1]}}, shreg_q};
    end
  endgenerate

  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    overrun_d = overrun_q;

    if (trigger && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          shreg_d = '0;
          div_d   = '0;
          phase_d = '0;
        end
      end
      S_SETUP: begin
        if (div_done) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_done) begin
          div_d   = '0;
          phase_d = phase_q + 1'b1;
          // Even phases are sck-high; data is captured as each high phase ends.
          if (!phase_q[0]) begin
            shreg_d = {shreg_q[DATA_WIDTH-2:0], sdo};
            sck_d   = 1'b0;
          end else if (phase_q == PH_LAST) begin
            cs_n_d   = 1'b1;
            tdata_d  = sext;
            tvalid_d = 1'b1;
            tlast_d  = (cnt_q == CNT_LAST);
            state_d  = S_OUT;
          end else begin
            sck_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_OUT: begin
        if (m_axis.tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          cnt_d    = tlast_q ? '0 : cnt_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tdata_q   <= tdata_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      overrun_q <= overrun_d;
    end
  end

  assign cs_n          = cs_n_q;
  assign sck           = sck_q;
  assign overrun       = overrun_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign ready         = (state_q == S_IDLE);
  assign last          = (state_q == S_OUT) && m_axis.tready && tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_readout
// Brief    : Self-checking bench for adc_readout with an SPI ADC model.
// Revision : 1.0
// ============================================================================
module tb_adc_readout;

  localparam int DW      = 24;
  localparam int DIV     = 2;
  localparam int PLEN    = 4;
  localparam int TV_EDGE = DIV * (2 * DW + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trigger = 1'b0;
  logic sdo = 1'b0;
  logic cs_n, sck, ready, last, overrun;

  adc_readout_if axis ();

  adc_readout #(.DATA_WIDTH(DW), .SCK_DIV(DIV), .PACKET_LEN(PLEN)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .cs_n(cs_n), .sck(sck),
    .sdo(sdo), .m_axis(axis), .ready(ready), .last(last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int beat_no = 0;

  // ADC model: presents the next MSB-first bit on every sck rise.
  logic [DW-1:0] adc_word = '0;
  int bit_idx = 0;
  always @(negedge cs_n) bit_idx = 0;
  always @(posedge sck) begin
    if (bit_idx < DW) sdo = adc_word[5'(DW - 1 - bit_idx)];
    bit_idx++;
  end

  function automatic logic [31:0] ref_sext(input logic [DW-1:0] w);
    longint v = longint'(w);
    if (v >= (longint'(1) << (DW - 1))) v = v - (longint'(1) << DW);
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    trigger = 1'b0;
    axis.tready = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    beat_no = 0;
  endtask

  task automatic run_read(
    input  logic [DW-1:0] w, input int stall, input int retrig, input bit trig_hs,
    output int tv_edge, output int csn_rise, output int pulses, output logic csn_e0,
    output logic [31:0] data, output logic tl, output logic last_hs, output logic hold_ok,
    output logic rdy_after, output logic tv_after, output logic ovr_before, output logic ovr_after);
    int e;
    logic sck_prev;
    adc_word = w;
    axis.tready = (stall == 0);
    tv_edge = -1; csn_rise = -1; pulses = 0; data = '0; tl = 1'b0; last_hs = 1'b0;
    hold_ok = 1'b1; rdy_after = 1'b0; tv_after = 1'b1;
    ovr_before = overrun; ovr_after = overrun;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    csn_e0 = cs_n;
    sck_prev = sck;
    e = 0;
    while (tv_edge < 0 && e < 300) begin
      if (retrig > 0 && e == retrig - 1) begin
        trigger = 1'b1;
        ovr_before = overrun;
      end
      step();
      e++;
      trigger = 1'b0;
      if (retrig > 0 && e == retrig + 1) ovr_after = overrun;
      if (sck && !sck_prev) pulses++;
      sck_prev = sck;
      if (cs_n && csn_rise < 0) csn_rise = e;
      if (axis.tvalid) begin
        tv_edge = e;
        data = axis.tdata;
        tl = axis.tlast;
      end
    end
    if (tv_edge < 0) return;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!axis.tvalid || axis.tdata !== data || ready !== 1'b0) hold_ok = 1'b0;
    end
    axis.tready = 1'b1;
    if (trig_hs) trigger = 1'b1;
    #1;
    last_hs = last;
    step();
    trigger = 1'b0;
    rdy_after = ready;
    tv_after = axis.tvalid;
  endtask

  task automatic test_reset();
    apply_reset(4);
    n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b expected 0", sck); end
    n_cmp++; if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tvalid_tlast: got %b%b expected 00", axis.tvalid, axis.tlast); end
    n_cmp++; if (axis.tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h expected 0", axis.tdata); end
    n_cmp++; if (ready !== 1'b1 || last !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_ready_last_overrun: got %b%b%b expected 100", ready, last, overrun); end
  endtask

  task automatic test_single_read(input logic [DW-1:0] w, input string nm);
    int tv, cr, p; logic ce, tl, lh, ho, ra, ta, ob, oa; logic [31:0] d; logic exp_tl;
    exp_tl = ((beat_no % PLEN) == PLEN - 1);
    run_read(w, 0, 0, 1'b0, tv, cr, p, ce, d, tl, lh, ho, ra, ta, ob, oa);
    beat_no++;
    n_cmp++; if (d !== ref_sext(w)) begin n_err++; $display("FAIL %s_tdata: got %h expected %h", nm, d, ref_sext(w)); end
    n_cmp++; if (tv !== TV_EDGE) begin n_err++; $display("FAIL %s_tvalid_edge: got %0d expected %0d", nm, tv, TV_EDGE); end
    n_cmp++; if (ta !== 1'b0 || ra !== 1'b1) begin n_err++; $display("FAIL %s_one_cycle_beat: tvalid %b ready %b expected 0 1", nm, ta, ra); end
    n_cmp++; if (p !== DW) begin n_err++; $display("FAIL %s_sck_pulses: got %0d expected %0d", nm, p, DW); end
    n_cmp++; if (ce !== 1'b0 || cr !== TV_EDGE) begin n_err++; $display("FAIL %s_cs_window: cs_n@E0 %b rise %0d expected 0 %0d", nm, ce, cr, TV_EDGE); end
    n_cmp++; if (tl !== exp_tl) begin n_err++; $display("FAIL %s_tlast: got %b expected %b", nm, tl, exp_tl); end
  endtask

  task automatic test_backpressure();
    int tv, cr, p; logic ce, tl, lh, ho, ra, ta, ob, oa; logic [31:0] d;
    logic [DW-1:0] w;
    w = DW'($urandom);
    run_read(w, 10, 0, 1'b0, tv, cr, p, ce, d, tl, lh, ho, ra, ta, ob, oa);
    beat_no++;
    n_cmp++; if (d !== ref_sext(w)) begin n_err++; $display("FAIL bp_tdata: got %h expected %h", d, ref_sext(w)); end
    n_cmp++; if (ho !== 1'b1) begin n_err++; $display("FAIL bp_hold_stable: got %b expected 1", ho); end
    n_cmp++; if (ra !== 1'b1 || ta !== 1'b0) begin n_err++; $display("FAIL bp_ready_after: ready %b tvalid %b expected 1 0", ra, ta); end
  endtask

  task automatic test_packet();
    int tv, cr, p; logic ce, tl, lh, ho, ra, ta, ob, oa; logic [31:0] d;
    logic [DW-1:0] w; logic exp_tl;
    apply_reset(2);
    for (int i = 0; i < 6; i++) begin
      w = DW'($urandom);
      exp_tl = ((beat_no % PLEN) == PLEN - 1);
      run_read(w, 0, 0, 1'b0, tv, cr, p, ce, d, tl, lh, ho, ra, ta, ob, oa);
      beat_no++;
      n_cmp++; if (tl !== exp_tl) begin n_err++; $display("FAIL pkt_tlast beat %0d: got %b expected %b", i + 1, tl, exp_tl); end
      n_cmp++; if (lh !== exp_tl) begin n_err++; $display("FAIL pkt_last beat %0d: got %b expected %b", i + 1, lh, exp_tl); end
      n_cmp++; if (last !== 1'b0) begin n_err++; $display("FAIL pkt_last_width beat %0d: got %b expected 0", i + 1, last); end
    end
  endtask

  task automatic test_overrun();
    int tv, cr, p, extra; logic ce, tl, lh, ho, ra, ta, ob, oa; logic [31:0] d;
    logic [DW-1:0] w;
    apply_reset(2);
    w = DW'($urandom);
    run_read(w, 0, 10, 1'b0, tv, cr, p, ce, d, tl, lh, ho, ra, ta, ob, oa);
    beat_no++;
    n_cmp++; if (ob !== 1'b0 || oa !== 1'b1) begin n_err++; $display("FAIL ovr_flag: before %b after %b expected 0 1", ob, oa); end
    n_cmp++; if (d !== ref_sext(w) || tv !== TV_EDGE) begin n_err++; $display("FAIL ovr_read: data %h edge %0d expected %h %0d", d, tv, ref_sext(w), TV_EDGE); end
    extra = 0;
    repeat (120) begin step(); if (axis.tvalid || !cs_n) extra++; end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ovr_single_beat: got %0d extra busy cycles expected 0", extra); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    apply_reset(1);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_reset_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_trigger_at_handshake();
    int tv, cr, p, busy; logic ce, tl, lh, ho, ra, ta, ob, oa; logic [31:0] d;
    run_read(DW'($urandom), 0, 0, 1'b1, tv, cr, p, ce, d, tl, lh, ho, ra, ta, ob, oa);
    beat_no++;
    n_cmp++; if (ra !== 1'b1 || overrun !== 1'b1) begin n_err++; $display("FAIL hs_trig: ready %b overrun %b expected 1 1", ra, overrun); end
    busy = 0;
    repeat (6) begin step(); if (!cs_n || !ready) busy++; end
    n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL hs_trig_ignored: got %0d busy cycles expected 0", busy); end
  endtask

  task automatic test_reset_midread();
    int seen;
    apply_reset(2);
    adc_word = DW'($urandom);
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (30) step();
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++; if (cs_n !== 1'b1 || sck !== 1'b0 || ready !== 1'b1 || axis.tvalid !== 1'b0) begin
      n_err++; $display("FAIL midreset_state: cs_n %b sck %b ready %b tvalid %b expected 1 0 1 0", cs_n, sck, ready, axis.tvalid); end
    seen = 0;
    repeat (120) begin step(); if (axis.tvalid || !cs_n) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midreset_no_beat: got %0d busy cycles expected 0", seen); end
    beat_no = 0;
  endtask

  task automatic test_random();
    int tv, cr, p, st; logic ce, tl, lh, ho, ra, ta, ob, oa; logic [31:0] d;
    logic [DW-1:0] w; logic exp_tl;
    for (int i = 0; i < 10; i++) begin
      w = DW'($urandom);
      st = int'($urandom_range(0, 3));
      exp_tl = ((beat_no % PLEN) == PLEN - 1);
      run_read(w, st, 0, 1'b0, tv, cr, p, ce, d, tl, lh, ho, ra, ta, ob, oa);
      beat_no++;
      n_cmp++; if (d !== ref_sext(w) || tl !== exp_tl || ho !== 1'b1) begin
        n_err++; $display("FAIL rand_%0d: tdata %h tlast %b hold %b expected %h %b 1", i, d, tl, ho, ref_sext(w), exp_tl); end
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    test_reset();
    test_single_read(24'h800001, "neg");
    test_single_read(24'h7FFFFF, "pos");
    test_backpressure();
    test_packet();
    test_overrun();
    test_trigger_at_handshake();
    test_reset_midread();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
